block_lock_ctrl: RTL and testbench
==================================

Name: block_lock_ctrl

Overview:
Sequences 66b block-header alignment on the RX path. Takes the candidate header offset from the header seeker and loads it into the gearbox slice selector. Waits for the datapath to settle, then qualifies the offset by counting consecutive valid sync headers. Once locked, it monitors header errors over a sliding window and re-acquires when the error rate is too high. Sits between the header seeker / gearbox and the block decoder; block_lock_o gates downstream descrambling.

Parameters:
LOCK_CNT, 32, consecutive valid headers required to declare lock (>=1)
WIN_LEN, 64, headers per error-monitoring window in LOCKED (>=1)
BAD_MAX, 16, invalid headers within one window that force loss of lock (1..WIN_LEN)
SETTLE_CYC, 4, clock cycles ignored after each offset load, covering gearbox/header pipeline latency (>=1)
OFFSET_W, 7, width of block offset

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  enable; low forces IDLE
cand_offset_i  in  OFFSET_W  candidate header offset from seeker, sampled on each load
hdr_i  in  2  sync header of current block
hdr_dv_i  in  1  hdr_i valid this cycle
offset_o  out  OFFSET_W  offset applied to gearbox slice selector
offset_ld_o  out  1  one-cycle pulse when offset_o changes
block_lock_o  out  1  block alignment achieved
slip_cnt_o  out  16  count of re-acquisitions (saturating)
state_o  out  2  current state: IDLE=0, SETTLE=1, TEST=2, LOCKED=3

Behaviour:
- Valid header: hdr_i == 2'b01 or 2'b10. 2'b00 and 2'b11 are invalid. hdr_i is only examined when hdr_dv_i=1 and state is TEST or LOCKED.
- Reset (async assert, sync release): state IDLE; offset_o=0, offset_ld_o=0, block_lock_o=0, slip_cnt_o=0; all internal counters 0.
- "Reload" action, performed on the transition edge:
  - offset_o <= cand_offset_i.
  - offset_ld_o=1 for exactly the following cycle.
  - settle counter cleared; next state SETTLE.
- IDLE: if en_i=1, perform reload. No slip increment.
- SETTLE:
  - Counts clock cycles; hdr_dv_i ignored.
  - After SETTLE_CYC cycles in SETTLE, go to TEST with good_cnt=0.
  - Load-to-first-qualified-header latency = SETTLE_CYC+1 cycles.
- TEST:
  - On valid header: good_cnt++.
  - On the LOCK_CNT-th consecutive valid header: go to LOCKED; block_lock_o=1 from the next cycle; window and bad counters cleared.
  - On invalid header: slip_cnt_o++ (saturates at 16'hFFFF, no wrap), then reload.
- LOCKED:
  - Each hdr_dv_i increments win_cnt; each invalid header increments bad_cnt.
  - When bad_cnt reaches BAD_MAX: block_lock_o=0 next cycle, slip_cnt_o++, reload.
  - When win_cnt reaches WIN_LEN with bad_cnt < BAD_MAX: clear both counters and stay LOCKED.
  - Simultaneous case (WIN_LEN-th header is also the BAD_MAX-th invalid): loss of lock wins.
- en_i=0 in any state:
  - Next state IDLE; block_lock_o=0; offset_ld_o=0; good/win/bad/settle counters cleared.
  - offset_o and slip_cnt_o retained.
  - en_i has priority over every other transition in the same cycle.
- cand_offset_i is sampled only on reload; changes in other cycles have no effect.
- offset_o never changes without a coincident-next-cycle offset_ld_o pulse.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).

Test Plan:
- Reset then en_i=1, cand_offset_i=7'd23, continuous valid headers 2'b01 -> offset_o=23 with one offset_ld_o pulse; state SETTLE for 4 cycles; block_lock_o=1 the cycle after the 32nd valid header.
- In TEST, 10 valid headers then hdr_i=2'b11 with cand_offset_i=7'd40 -> slip_cnt_o=1, offset_o=40, offset_ld_o pulse, good_cnt restarts; lock only after 32 further consecutive valid headers.
- Locked, 15 invalid headers spread over 64-header windows, repeated for 3 windows -> block_lock_o stays 1, slip_cnt_o unchanged.
- Locked, 16 invalid headers within one window -> block_lock_o=0 the cycle after the 16th invalid, slip_cnt_o increments, reload occurs; also cover the case where the 64th header is the 16th invalid -> lock lost.
- en_i dropped while LOCKED, then raised -> state IDLE, block_lock_o=0, offset_o held, slip_cnt_o held; re-enable issues a fresh reload with no slip increment.
- Force slip_cnt_o to 16'hFFFF via repeated invalid headers in TEST, then one more failure -> slip_cnt_o stays 16'hFFFF; assert rst_ni mid-SETTLE -> all outputs 0 immediately.

Source files
------------

// File: rtl/block_lock_ctrl.sv
// 66b block-header lock sequencer: loads a candidate offset into the gearbox, waits for the
// pipeline to settle, qualifies the offset on consecutive valid headers, then polices errors.
module block_lock_ctrl #(
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned WIN_LEN    = 64,
    parameter int unsigned BAD_MAX    = 16,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned OFFSET_W   = 7
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [OFFSET_W-1:0] cand_offset_i,
    input  logic [1:0]          hdr_i,
    input  logic                hdr_dv_i,
    output logic [OFFSET_W-1:0] offset_o,
    output logic                offset_ld_o,
    output logic                block_lock_o,
    output logic [15:0]         slip_cnt_o,
    output logic [1:0]          state_o
);

    localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WinW  = $clog2(WIN_LEN + 1);
    localparam int unsigned BadW  = $clog2(BAD_MAX + 1);
    localparam int unsigned SetW  = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StTest   = 2'd2,
        StLocked = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic                offset_ld_q, offset_ld_d;
    logic                lock_q, lock_d;
    logic [15:0]         slip_q, slip_d;
    logic [SetW-1:0]     settle_q, settle_d;
    logic [GoodW-1:0]    good_q, good_d;
    logic [WinW-1:0]     win_q, win_d;
    logic [BadW-1:0]     bad_q, bad_d;

    logic                hdr_ok;
    logic                reload;
    logic [15:0]         slip_inc;
    logic [WinW-1:0]     win_nx;
    logic [BadW-1:0]     bad_nx;

    // 01 and 10 are the only legal sync headers
    assign hdr_ok   = hdr_i[0] ^ hdr_i[1];
    assign slip_inc = (slip_q == 16'hFFFF) ? slip_q : slip_q + 16'd1;
    assign win_nx   = win_q + WinW'(1);
    assign bad_nx   = bad_q + BadW'(hdr_ok ? 0 : 1);

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        offset_ld_d = 1'b0;
        lock_d      = lock_q;
        slip_d      = slip_q;
        settle_d    = settle_q;
        good_d      = good_q;
        win_d       = win_q;
        bad_d       = bad_q;
        reload      = 1'b0;

        if (!en_i) begin
            state_d  = StIdle;
            lock_d   = 1'b0;
            settle_d = '0;
            good_d   = '0;
            win_d    = '0;
            bad_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: reload = 1'b1;
                StSettle: begin
                    if (settle_q == SetW'(SETTLE_CYC - 1)) begin
                        state_d = StTest;
                        good_d  = '0;
                    end else begin
                        settle_d = settle_q + SetW'(1);
                    end
                end
                StTest: begin
                    if (hdr_dv_i) begin
                        if (!hdr_ok) begin
                            slip_d = slip_inc;
                            reload = 1'b1;
                        end else if (good_q == GoodW'(LOCK_CNT - 1)) begin
                            state_d = StLocked;
                            lock_d  = 1'b1;
                            win_d   = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + GoodW'(1);
                        end
                    end
                end
                StLocked: begin
                    if (hdr_dv_i) begin
                        // Loss of lock outranks the window rollover on the same header
                        if (bad_nx == BadW'(BAD_MAX)) begin
                            lock_d = 1'b0;
                            slip_d = slip_inc;
                            reload = 1'b1;
                        end else if (win_nx == WinW'(WIN_LEN)) begin
                            win_d = '0;
                            bad_d = '0;
                        end else begin
                            win_d = win_nx;
                            bad_d = bad_nx;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            if (reload) begin
                offset_d    = cand_offset_i;
                offset_ld_d = 1'b1;
                settle_d    = '0;
                good_d      = '0;
                win_d       = '0;
                bad_d       = '0;
                state_d     = StSettle;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            offset_q    <= '0;
            offset_ld_q <= 1'b0;
            lock_q      <= 1'b0;
            slip_q      <= '0;
            settle_q    <= '0;
            good_q      <= '0;
            win_q       <= '0;
            bad_q       <= '0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            offset_ld_q <= offset_ld_d;
            lock_q      <= lock_d;
            slip_q      <= slip_d;
            settle_q    <= settle_d;
            good_q      <= good_d;
            win_q       <= win_d;
            bad_q       <= bad_d;
        end
    end

    assign offset_o     = offset_q;
    assign offset_ld_o  = offset_ld_q;
    assign block_lock_o = lock_q;
    assign slip_cnt_o   = slip_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_block_lock_ctrl.sv
// Bench for block_lock_ctrl: directed header streams checked every cycle against a
// rule-level model (window kept as a queue of error flags), plus literal spot checks.
module tb_block_lock_ctrl;

    localparam int unsigned LockCnt   = 32;
    localparam int unsigned WinLen    = 64;
    localparam int unsigned BadMax    = 16;
    localparam int unsigned SettleCyc = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       en_i;
    logic [6:0] cand_offset_i;
    logic [1:0] hdr_i;
    logic       hdr_dv_i;
    logic [6:0] offset_o;
    logic       offset_ld_o;
    logic       block_lock_o;
    logic [15:0] slip_cnt_o;
    logic [1:0] state_o;

    block_lock_ctrl #(
        .LOCK_CNT  (LockCnt),
        .WIN_LEN   (WinLen),
        .BAD_MAX   (BadMax),
        .SETTLE_CYC(SettleCyc),
        .OFFSET_W  (7)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .cand_offset_i(cand_offset_i),
        .hdr_i        (hdr_i),
        .hdr_dv_i     (hdr_dv_i),
        .offset_o     (offset_o),
        .offset_ld_o  (offset_ld_o),
        .block_lock_o (block_lock_o),
        .slip_cnt_o   (slip_cnt_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Model: state number, elapsed settle cycles, good-header run, error flags of this window
    int m_state, m_off, m_ld, m_lock, m_slip, m_settle, m_good;
    bit m_win[$];

    task automatic cmp(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int win_errors();
        int s = 0;
        foreach (m_win[i]) s += int'(m_win[i]);
        return s;
    endfunction

    task automatic model_reset();
        m_state = 0; m_off = 0; m_ld = 0; m_lock = 0; m_slip = 0; m_settle = 0; m_good = 0;
        m_win.delete();
    endtask

    task automatic model_step();
        bit valid;
        bit rl;
        valid = (hdr_i == 2'b01) || (hdr_i == 2'b10);
        rl    = 1'b0;
        m_ld  = 0;
        if (!en_i) begin
            m_state = 0; m_lock = 0; m_settle = 0; m_good = 0;
            m_win.delete();
        end else begin
            case (m_state)
                0: rl = 1'b1;
                1: begin
                    m_settle++;
                    if (m_settle == SettleCyc) begin m_state = 2; m_good = 0; end
                end
                2: if (hdr_dv_i) begin
                    if (valid) begin
                        m_good++;
                        if (m_good == LockCnt) begin
                            m_state = 3; m_lock = 1; m_win.delete();
                        end
                    end else begin
                        if (m_slip < 65535) m_slip++;
                        rl = 1'b1;
                    end
                end
                default: if (hdr_dv_i) begin
                    m_win.push_back(!valid);
                    if (win_errors() >= BadMax) begin
                        m_lock = 0;
                        if (m_slip < 65535) m_slip++;
                        rl = 1'b1;
                    end else if (m_win.size() == WinLen) begin
                        m_win.delete();
                    end
                end
            endcase
        end
        if (rl) begin
            m_off = int'(cand_offset_i); m_ld = 1; m_state = 1; m_settle = 0; m_good = 0;
            m_win.delete();
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_on && rst_ni) begin
            cmp("state_o", state_o, m_state);
            cmp("offset_o", offset_o, m_off);
            cmp("offset_ld_o", offset_ld_o, m_ld);
            cmp("block_lock_o", block_lock_o, m_lock);
            cmp("slip_cnt_o", slip_cnt_o, m_slip);
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            model_step();
            #1;
        end
    endtask

    task automatic drive(input bit en, input int cand, input logic [1:0] hdr, input bit dv);
        en_i = en; cand_offset_i = 7'(cand); hdr_i = hdr; hdr_dv_i = dv;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(0, 0, 2'b00, 0);
        model_reset();
        #12;
        cmp("reset state", state_o, 0);
        cmp("reset offset", offset_o, 0);
        cmp("reset ld", offset_ld_o, 0);
        cmp("reset lock", block_lock_o, 0);
        cmp("reset slip", slip_cnt_o, 0);
        rst_ni = 1'b1;
        chk_on = 1'b1;

        // First acquisition at offset 23
        drive(1, 23, 2'b01, 1);
        cyc();
        cmp("load offset 23", offset_o, 23);
        cmp("load pulse", offset_ld_o, 1);
        cmp("settle state", state_o, 1);
        cand_offset_i = 7'd99;  // must be ignored outside reload
        cyc(SettleCyc);
        cmp("test after settle", state_o, 2);
        cyc(LockCnt - 1);
        cmp("no lock at 31", block_lock_o, 0);
        cyc();
        cmp("lock at 32", block_lock_o, 1);
        cmp("offset held 23", offset_o, 23);

        // Disable while locked, then re-enable
        drive(0, 5, 2'b01, 1);
        cyc();
        cmp("disable idle", state_o, 0);
        cmp("disable unlock", block_lock_o, 0);
        cmp("disable offset held", offset_o, 23);
        cyc(3);
        drive(1, 5, 2'b01, 1);
        cyc();
        cmp("reenable offset", offset_o, 5);
        cmp("reenable slip", slip_cnt_o, 0);

        // Slip in TEST after 10 good headers
        cyc(SettleCyc + 10);
        drive(1, 40, 2'b11, 1);
        cyc();
        cmp("test slip count", slip_cnt_o, 1);
        cmp("test slip offset", offset_o, 40);
        cmp("test slip pulse", offset_ld_o, 1);
        drive(1, 77, 2'b10, 1);
        cyc(SettleCyc + LockCnt - 1);
        cmp("no early relock", block_lock_o, 0);
        cyc();
        cmp("relock", block_lock_o, 1);

        // Three windows each carrying 15 errors, with idle gaps
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < WinLen; i++) begin
                if (i % 16 == 7) begin
                    drive(1, 77, 2'b11, 0);
                    cyc();
                end
                drive(1, 77, ((i % 4 == 0) && (i < 60)) ? 2'b00 : 2'b10, 1);
                cyc();
            end
        end
        cmp("15 errs keep lock", block_lock_o, 1);
        cmp("15 errs no slip", slip_cnt_o, 1);

        // 16 errors back to back
        drive(1, 9, 2'b11, 1);
        cyc(BadMax - 1);
        cmp("lock at 15 errs", block_lock_o, 1);
        cyc();
        cmp("unlock at 16 errs", block_lock_o, 0);
        cmp("slip at 16 errs", slip_cnt_o, 2);
        cmp("reload at 16 errs", offset_o, 9);
        drive(1, 9, 2'b01, 1);
        cyc(SettleCyc + LockCnt);
        cmp("relock 2", block_lock_o, 1);

        // 64th header of the window is the 16th error
        cyc(WinLen - BadMax);
        drive(1, 11, 2'b00, 1);
        cyc(BadMax - 1);
        cmp("lock before window end", block_lock_o, 1);
        cyc();
        cmp("window-end unlock", block_lock_o, 0);
        cmp("window-end slip", slip_cnt_o, 3);

        // Saturation of the slip counter
        drive(0, 11, 2'b01, 1);
        cyc(2);
        force dut.slip_q = 16'hFFFE;
        #1;
        release dut.slip_q;
        m_slip = 16'hFFFE;
        drive(1, 12, 2'b11, 1);
        cyc(1 + SettleCyc + 1);
        cmp("slip to ffff", slip_cnt_o, 16'hFFFF);
        cyc(SettleCyc + 1);
        cmp("slip saturates", slip_cnt_o, 16'hFFFF);
        cmp("state after sat", state_o, 1);

        // Asynchronous reset in SETTLE
        cyc(2);
        #2;
        rst_ni = 1'b0;
        #1;
        cmp("async rst state", state_o, 0);
        cmp("async rst offset", offset_o, 0);
        cmp("async rst ld", offset_ld_o, 0);
        cmp("async rst lock", block_lock_o, 0);
        cmp("async rst slip", slip_cnt_o, 0);
        model_reset();
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        drive(1, 3, 2'b10, 1);
        cyc(SettleCyc + LockCnt + 2);
        cmp("lock after reset", block_lock_o, 1);

        @(negedge clk_i);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
